// File: rtl/multi_timer.sv
// multi_timer
//   Parametrised multi-channel down-counting timer. CHANNELS independent
//   WIDTH-bit counters share one count-enable tick. Each channel runs either
//   one-shot or periodic (auto-reload) and emits a one-cycle expiry pulse.
//
// Optional feature: define TIMER_PRESCALE_EN to add a shared prescaler.
//   The macro adds the `prescale` input. The tick then fires on every
//   (prescale+1)-th count_en pulse.
//
// Ports
//   clock       in   1               system clock, rising edge
//   reset       in   1               asynchronous, active-low
//   count_en    in   1               global tick enable
//   prescale    in   PRESCALE_W      prescaler threshold (TIMER_PRESCALE_EN only)
//   load        in   CHANNELS        per-channel load strobe
//   load_value  in   CHANNELS*WIDTH  channel i value at [i*WIDTH +: WIDTH]
//   periodic    in   CHANNELS        sampled on load: 1 = auto-reload
//   stop        in   CHANNELS        per-channel abort strobe
//   count       out  CHANNELS*WIDTH  current counter value per channel
//   running     out  CHANNELS        1 while channel is in RUN
//   expired     out  CHANNELS        one-cycle pulse on channel expiry
module multi_timer #(
    parameter int WIDTH      = 9,
    parameter int CHANNELS   = 4,
    parameter int PRESCALE_W = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      count_en,
`ifdef TIMER_PRESCALE_EN
    input  logic [PRESCALE_W-1:0]     prescale,
`endif
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS*WIDTH-1:0] load_value,
    input  logic [CHANNELS-1:0]       periodic,
    input  logic [CHANNELS-1:0]       stop,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       running,
    output logic [CHANNELS-1:0]       expired
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    if (CHANNELS < 1 || PRESCALE_W < 1) begin : g_param_check
        $error("multi_timer: CHANNELS and PRESCALE_W must be at least 1");
    end

    logic tick;

`ifdef TIMER_PRESCALE_EN
    logic [PRESCALE_W-1:0] pcnt;

    // >= rather than == so that lowering prescale below the current
    // count cannot strand the prescaler waiting for a wrap-around.
    assign tick = count_en && (pcnt >= prescale);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pcnt <= '0;
        end else if (count_en) begin
            if (pcnt >= prescale) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + 1'b1;
            end
        end
    end
`else
    assign tick = count_en;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [0:0]       state;
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] reload;
        logic             mode;
        logic             exp_q;
        logic [WIDTH-1:0] lv;

        assign lv = load_value[i*WIDTH +: WIDTH];

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                state  <= IDLE;
                cnt    <= '0;
                reload <= '0;
                mode   <= 1'b0;
                exp_q  <= 1'b0;
            end else begin
                exp_q <= 1'b0;
                if (stop[i]) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else if (load[i]) begin
                    if (lv != '0) begin
                        cnt    <= lv;
                        reload <= lv;
                        mode   <= periodic[i];
                        state  <= RUN;
                    end else begin
                        // A zero load expires immediately, whatever the mode.
                        cnt   <= '0;
                        state <= IDLE;
                        exp_q <= 1'b1;
                    end
                end else if (tick && state == RUN) begin
                    // In RUN the counter is never 0, so the decrement cannot wrap.
                    if (cnt == WIDTH'(1)) begin
                        exp_q <= 1'b1;
                        if (mode) begin
                            cnt <= reload;
                        end else begin
                            cnt   <= '0;
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
            end
        end

        assign count[i*WIDTH +: WIDTH] = cnt;
        assign running[i]              = (state == RUN);
        assign expired[i]              = exp_q;
    end

endmodule
